dcache_wb_buffer: RTL and testbench
===================================

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high, ports named clock and reset.
REQ-002 SHALL provide parameter WB_DEPTH, default 4, number of victim entries (power of two, >=2).
REQ-003 SHALL provide these ports; unlisted widths are 1:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- evict_en  in  1  dirty valid victim presented by Dcache
- evict_addr  in  SASS_ADDR  victim line address
- evict_data  in  64  victim line data
- evict_ready  out  1  buffer can accept a victim this cycle
- mem_grant  in  1  memory arbiter grants bus to buffer this cycle
- mem2proc_response  in  4  nonzero = store accepted
- proc2mem_command  out  2  BUS_NONE or BUS_STORE
- proc2mem_addr  out  64  store address
- proc2mem_data  out  64  store data
- search_addr  in  SASS_ADDR  load/miss lookup address
- search_hit  out  1  search_addr matches a buffered entry
- search_data  out  64  data of matching entry
- wb_count  out  $clog2(WB_DEPTH)+1  occupied entries
- wb_empty  out  1  wb_count == 0

Function
REQ-004 SHALL hold entries in a circular FIFO (head, tail pointers, wrap at WB_DEPTH) ordered oldest first.
REQ-005 SHALL drive evict_ready = (wb_count < WB_DEPTH) from registered count only; a pop in the same cycle never frees space for a push.
REQ-006 SHALL push {evict_addr, evict_data} at tail on evict_en & evict_ready; evict_en while !evict_ready is ignored (upstream stalls).
REQ-007 SHALL coalesce: if evict_en hits an entry with equal tag and set_index that is not popping this cycle, overwrite that entry's data in place, leave wb_count unchanged; this takes effect even when full.
REQ-008 SHALL allocate a new tail entry when the only address match is the head popping that cycle.
REQ-009 SHALL implement FSM IDLE/SEND: IDLE->SEND when !wb_empty; SEND->IDLE when the last entry pops and no push occurs that cycle.
REQ-010 SHALL, in SEND with mem_grant, drive proc2mem_command = BUS_STORE, proc2mem_addr/data = head entry; otherwise BUS_NONE, addr/data 0.
REQ-011 SHALL pop head when BUS_STORE is driven and mem2proc_response != 0; response 0 means retry same head next granted cycle.
REQ-012 SHALL update wb_count by +1 (push only), -1 (pop only), 0 (both, coalesce, or neither).
REQ-013 SHALL drive wb_empty and wb_count from registered state, with no combinational path from inputs.

Reset
REQ-014 SHALL on reset: FSM=IDLE, head=tail=0, wb_count=0, all entries invalid, evict_ready=1, wb_empty=1, proc2mem_command=BUS_NONE, search_hit=0, search_data=0.
REQ-015 SHALL abandon an in-flight store on reset mid-SEND; the entry is lost, by design.

Configuration
REQ-016 SHALL with WB_FWD_EN defined: search_hit/search_data are combinational from search_addr against all valid entries, including the head being sent; a same-cycle coalesce write is not visible until next cycle.
REQ-017 SHALL with WB_FWD_EN undefined: search_hit=0, search_data=0, no comparators synthesized.

Structure
REQ-018 SHALL take SASS_ADDR, BUS_NONE/BUS_STORE from the shared sys_defs package; WB_ENTRY_t {valid, addr, data} typedef SHALL be added there.
REQ-019 SHALL be a single module; no sub-module, FIFO and CAM in-line.

Verification
REQ-020 SHALL be covered by these directed scenarios:
- push A=0x100 data 0x11, grant, response=1 -> BUS_STORE 0x100/0x11 in SEND, popped, wb_empty=1 next cycle.
- fill 4 distinct, 5th evict_en -> evict_ready=0, 5th ignored, wb_count=4; same-cycle pop does not accept it.
- push 0x200/0xAA then 0x200/0xBB while head busy elsewhere -> wb_count unchanged, later store carries 0xBB.
- response=0 for 3 granted cycles then 2 -> same head repeated 3 times, popped on 4th.
- WB_FWD_EN: buffer holds 0x300/0xCC, search 0x300 -> search_hit=1, data 0xCC; undefined -> hit=0.
- reset asserted asynchronously mid-SEND with 3 entries -> all outputs at reset values immediately, wb_count=0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared system types: address width, bus commands and the write-back buffer entry.
package sys_defs;

  localparam int SASS_ADDR_W = 32;
  typedef logic [SASS_ADDR_W-1:0] SASS_ADDR;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic        valid;
    SASS_ADDR    addr;
    logic [63:0] data;
  } WB_ENTRY_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SEND = 1'b1
  } wb_state_t;

endpackage

// File: rtl/dcache_wb_buffer.sv
// Dirty-victim write-back FIFO with coalescing; drains oldest-first as BUS_STORE when granted.
// WB_FWD_EN adds a combinational load-forwarding lookup over all valid entries.
module dcache_wb_buffer
  import sys_defs::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      evict_en,
  input  SASS_ADDR                  evict_addr,
  input  logic [63:0]               evict_data,
  output logic                      evict_ready,
  input  logic                      mem_grant,
  input  logic [3:0]                mem2proc_response,
  output logic [1:0]                proc2mem_command,
  output logic [63:0]               proc2mem_addr,
  output logic [63:0]               proc2mem_data,
  input  SASS_ADDR                  search_addr,
  output logic                      search_hit,
  output logic [63:0]               search_data,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_state_t  state;
  logic [PTR_W-1:0] head, tail;
  WB_ENTRY_t  entries [WB_DEPTH];

  logic             sending, pop, push, coalesce, coal_hit;
  logic [PTR_W-1:0] coal_idx;

  assign evict_ready = (wb_count < CNT_W'(WB_DEPTH));
  assign wb_empty    = (wb_count == '0);
  assign sending     = (state == WB_SEND) && mem_grant;
  assign pop         = sending && (mem2proc_response != 4'h0);

  // The head being popped this cycle is excluded so a re-eviction of the
  // same line gets a fresh tail entry instead of being lost with the head.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (!coal_hit && entries[i].valid && (entries[i].addr == evict_addr) &&
          !(pop && (PTR_W'(i) == head))) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  assign coalesce = evict_en && coal_hit;
  assign push     = evict_en && !coal_hit && evict_ready;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'h0;
    proc2mem_data    = 64'h0;
    if (sending) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = 64'(entries[head].addr);
      proc2mem_data    = entries[head].data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= WB_IDLE;
      head     <= '0;
      tail     <= '0;
      wb_count <= '0;
      for (int i = 0; i < WB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (coalesce) entries[coal_idx].data <= evict_data;
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: evict_addr, data: evict_data};
        tail          <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   wb_count <= wb_count + CNT_W'(1);
        2'b01:   wb_count <= wb_count - CNT_W'(1);
        default: wb_count <= wb_count;
      endcase
      case (state)
        WB_IDLE: if (!wb_empty) state <= WB_SEND;
        WB_SEND: if (pop && (wb_count == CNT_W'(1)) && !push) state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // A coalesce landing this cycle is only seen after the clock edge.
  always_comb begin
    search_hit  = 1'b0;
    search_data = 64'h0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr == search_addr)) begin
        search_hit  = 1'b1;
        search_data = entries[i].data;
      end
    end
  end
`else
  logic unused_search;
  assign unused_search = ^search_addr;
  assign search_hit    = 1'b0;
  assign search_data   = 64'h0;
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed table, hand-written corner sequences, and random traffic vs a queue model.
module tb_dcache_wb_buffer;
  import sys_defs::*;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        evict_en = 1'b0;
  SASS_ADDR    evict_addr = '0;
  logic [63:0] evict_data = '0;
  logic        evict_ready;
  logic        mem_grant = 1'b0;
  logic [3:0]  mem2proc_response = '0;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  SASS_ADDR    search_addr = '0;
  logic        search_hit;
  logic [63:0] search_data;
  logic [$clog2(D):0] wb_count;
  logic        wb_empty;

  always #5 clock = ~clock;

  dcache_wb_buffer #(.WB_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .evict_en(evict_en), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_ready(evict_ready),
    .mem_grant(mem_grant), .mem2proc_response(mem2proc_response),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .search_addr(search_addr), .search_hit(search_hit), .search_data(search_data),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } ent_t;

  ent_t q[$];
  bit   busy = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    bit          en;
    logic [31:0] a;
    logic [63:0] d;
    bit          g;
    logic [3:0]  r;
    logic [1:0]  cmd;
    logic [63:0] paddr;
    logic [63:0] pdata;
    int          cnt;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] ea, ed, sd;
    logic [1:0]  ec;
    bit          eh;
    bit          snd;
    snd = busy && mem_grant;
    ec  = snd ? 2'd2 : 2'd0;
    ea  = 64'h0;
    ed  = 64'h0;
    if (snd && q.size() > 0) begin
      ea = 64'(q[0].addr);
      ed = q[0].data;
    end
    eh = 1'b0;
    sd = 64'h0;
    if (FWD) begin
      foreach (q[i]) if (q[i].addr == search_addr) begin eh = 1'b1; sd = q[i].data; end
    end
    chk("wb_count", 64'(wb_count), 64'(q.size()));
    chk("wb_empty", 64'(wb_empty), 64'(q.size() == 0));
    chk("evict_ready", 64'(evict_ready), 64'(q.size() < D));
    chk("cmd", 64'(proc2mem_command), 64'(ec));
    chk("store_addr", proc2mem_addr, ea);
    chk("store_data", proc2mem_data, ed);
    chk("search_hit", 64'(search_hit), 64'(eh));
    chk("search_data", search_data, sd);
  endtask

  task automatic model_update();
    bit pop, push;
    int n, idx;
    pop  = busy && mem_grant && (mem2proc_response != 4'h0);
    push = 1'b0;
    n    = q.size();
    idx  = -1;
    if (evict_en) begin
      for (int i = 0; i < n; i++)
        if (idx < 0 && q[i].addr == evict_addr && !(pop && i == 0)) idx = i;
      if (idx >= 0) q[idx].data = evict_data;
      else if (n < D) push = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{addr: evict_addr, data: evict_data});
    if (!busy) busy = (n != 0);
    else if (pop && n == 1 && !push) busy = 1'b0;
  endtask

  task automatic step(input bit en, input logic [31:0] a, input logic [63:0] d,
                      input bit g, input logic [3:0] r, input logic [31:0] s);
    @(negedge clock);
    evict_en = en; evict_addr = a; evict_data = d;
    mem_grant = g; mem2proc_response = r; search_addr = s;
    #1;
    check_model();
    model_update();
  endtask

  initial begin
    // Single push/store, 3x retry then pop, and coalesce behind a busy head.
    vt[0]  = '{1'b1, 32'h100, 64'h11, 1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  0};
    vt[1]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd0, 64'h0,   64'h0,  1};
    vt[2]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd2, 64'h100, 64'h11, 1};
    vt[3]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd0, 64'h0,   64'h0,  0};
    vt[4]  = '{1'b1, 32'h180, 64'h22, 1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  0};
    vt[5]  = '{1'b0, 32'h0,   64'h0,  1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  1};
    vt[6]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd0, 2'd2, 64'h180, 64'h22, 1};
    vt[7]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd0, 2'd2, 64'h180, 64'h22, 1};
    vt[8]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd0, 2'd2, 64'h180, 64'h22, 1};
    vt[9]  = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd2, 2'd2, 64'h180, 64'h22, 1};
    vt[10] = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd0, 64'h0,   64'h0,  0};
    vt[11] = '{1'b1, 32'h400, 64'h01, 1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  0};
    vt[12] = '{1'b1, 32'h200, 64'hAA, 1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  1};
    vt[13] = '{1'b1, 32'h200, 64'hBB, 1'b1, 4'd0, 2'd2, 64'h400, 64'h01, 2};
    vt[14] = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd2, 64'h400, 64'h01, 2};
    vt[15] = '{1'b0, 32'h0,   64'h0,  1'b1, 4'd1, 2'd2, 64'h200, 64'hBB, 1};
    vt[16] = '{1'b0, 32'h0,   64'h0,  1'b0, 4'd0, 2'd0, 64'h0,   64'h0,  0};

    // Reset state, with a grant present to show the command stays idle.
    @(negedge clock);
    mem_grant = 1'b1;
    #1;
    chk("rst_count", 64'(wb_count), 64'h0);
    chk("rst_empty", 64'(wb_empty), 64'h1);
    chk("rst_ready", 64'(evict_ready), 64'h1);
    chk("rst_cmd", 64'(proc2mem_command), 64'h0);
    chk("rst_hit", 64'(search_hit), 64'h0);
    chk("rst_sdata", search_data, 64'h0);
    reset = 1'b0;
    mem_grant = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].en, vt[i].a, vt[i].d, vt[i].g, vt[i].r, 32'h0);
      chk($sformatf("tbl%0d_cmd", i), 64'(proc2mem_command), 64'(vt[i].cmd));
      chk($sformatf("tbl%0d_addr", i), proc2mem_addr, vt[i].paddr);
      chk($sformatf("tbl%0d_data", i), proc2mem_data, vt[i].pdata);
      chk($sformatf("tbl%0d_count", i), 64'(wb_count), 64'(vt[i].cnt));
    end

    // Fill, then evictions while full are dropped even with a same-cycle pop.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h500 + 32'(k * 8), 64'(k + 1), 1'b0, 4'd0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);
    chk("full_ready", 64'(evict_ready), 64'h0);
    chk("full_count", 64'(wb_count), 64'h4);
    step(1'b1, 32'h520, 64'h55, 1'b0, 4'd0, 32'h0);
    step(1'b1, 32'h528, 64'h66, 1'b1, 4'd1, 32'h0);
    chk("full_pop_addr", proc2mem_addr, 64'h500);
    chk("full_pop_ready", 64'(evict_ready), 64'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);
    chk("full_after_pop", 64'(wb_count), 64'h3);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 64'h0, 1'b1, 4'd1, 32'h0);
      chk("full_drain_addr", proc2mem_addr, 64'h508 + 64'(k * 8));
    end
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);
    chk("full_drained", 64'(wb_count), 64'h0);

    // Forwarding lookup, including while the entry is the head being sent.
    step(1'b1, 32'h300, 64'hCC, 1'b0, 4'd0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h300);
    chk("fwd_hit", 64'(search_hit), 64'(FWD));
    chk("fwd_data", search_data, FWD ? 64'hCC : 64'h0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 4'd0, 32'h300);
    chk("fwd_head_hit", 64'(search_hit), 64'(FWD));
    step(1'b0, 32'h0, 64'h0, 1'b1, 4'd1, 32'h300);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h300);
    chk("fwd_gone", 64'(search_hit), 64'h0);

    // Random traffic on a small line pool so coalescing and full stalls are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, s;
      logic [3:0]  r;
      a = 32'h1000 + 32'($urandom_range(0, 7) * 8);
      s = ($urandom_range(0, 3) == 0) ? 32'h2000 : 32'h1000 + 32'($urandom_range(0, 7) * 8);
      r = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(($urandom_range(0, 9) < 6), a, {$urandom, $urandom}, ($urandom_range(0, 2) != 0), r, s);
    end

    // Asynchronous reset in the middle of a store: the in-flight entry is dropped.
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 64'h0, 1'b1, 4'd1, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h600 + 32'(k * 8), 64'(k + 7), 1'b0, 4'd0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);
    @(negedge clock);
    evict_en = 1'b0; mem_grant = 1'b1; mem2proc_response = 4'd0; search_addr = 32'h600;
    #1;
    chk("pre_rst_cmd", 64'(proc2mem_command), 64'h2);
    chk("pre_rst_count", 64'(wb_count), 64'h3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cmd", 64'(proc2mem_command), 64'h0);
    chk("mid_rst_addr", proc2mem_addr, 64'h0);
    chk("mid_rst_count", 64'(wb_count), 64'h0);
    chk("mid_rst_empty", 64'(wb_empty), 64'h1);
    chk("mid_rst_ready", 64'(evict_ready), 64'h1);
    chk("mid_rst_hit", 64'(search_hit), 64'h0);
    chk("mid_rst_sdata", search_data, 64'h0);
    q.delete();
    busy = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 64'h0, 1'b1, 4'd1, 32'h600);
    step(1'b1, 32'h700, 64'h77, 1'b0, 4'd0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 4'd1, 32'h0);
    chk("post_rst_store", proc2mem_addr, 64'h700);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
